// File: rtl/inv_round_col_sequencer.sv
// Decryption round sequencer: AddRoundKey, then InvMixColumns one column per cycle via an external helper.
// Optional macro INV_COL_HELPER_REG_EN registers the helper result, which adds one MIX cycle.
module inv_round_col_sequencer #(
   parameter int NUM_COLS = 4,
   parameter int COL_W    = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_COLS*COL_W-1:0] in_state,
   input  logic [NUM_COLS*COL_W-1:0] in_key,
   input  logic                      in_skip_mix,
   output logic [COL_W-1:0]          col_out,
   input  logic [COL_W-1:0]          col_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_COLS*COL_W-1:0] out_state,
   output logic                      busy
);

   localparam int ST_W  = NUM_COLS * COL_W;
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

   typedef enum logic [1:0] {IDLE, MIX, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ST_W-1:0]     st_reg_q, st_reg_d;
   logic [ST_W-1:0]     res_q, res_d;
   logic [ST_W-1:0]     out_state_q, out_state_d;
   logic [ST_W-1:0]     res_next;
   logic [COL_W-1:0]    wr_col;
   logic [CNT_W-1:0]    wr_idx;
   logic                wr_en;
   logic                last_wr;
`ifdef INV_COL_HELPER_REG_EN
   logic [COL_W-1:0]    col_in_q, col_in_d;
   logic                pend_q, pend_d;
`endif

   // Column 0 sits in the MSBs of the 128-bit word.
   function automatic logic [COL_W-1:0] col_of(input logic [ST_W-1:0] s, input logic [CNT_W-1:0] c);
      col_of = '0;
      for (int i = 0; i < NUM_COLS; i++)
         if (c == CNT_W'(i)) col_of = s[ST_W-1-COL_W*i -: COL_W];
   endfunction

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_state = out_state_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      st_reg_d    = st_reg_q;
      res_d       = res_q;
      out_state_d = out_state_q;
      col_out     = col_of(st_reg_q, (state_q == MIX) ? cnt_q : '0);
`ifdef INV_COL_HELPER_REG_EN
      // Helper result arrives one cycle late, so the write lags the presented column by one.
      col_in_d = col_in;
      pend_d   = pend_q;
      wr_col   = col_in_q;
      wr_idx   = cnt_q - 1'b1;
      wr_en    = pend_q;
      last_wr  = pend_q && (cnt_q == '0);
`else
      wr_col   = col_in;
      wr_idx   = cnt_q;
      wr_en    = 1'b1;
      last_wr  = (cnt_q == LAST_COL);
`endif
      res_next = res_q;
      for (int i = 0; i < NUM_COLS; i++)
         if (wr_idx == CNT_W'(i)) res_next[ST_W-1-COL_W*i -: COL_W] = wr_col;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_reg_d = in_state ^ in_key;
               cnt_d    = '0;
               if (in_skip_mix) begin
                  out_state_d = in_state ^ in_key;
                  state_d     = DONE;
               end else begin
                  state_d = MIX;
               end
            end
         end
         MIX: begin
            if (wr_en) res_d = res_next;
            cnt_d = cnt_q + 1'b1;
`ifdef INV_COL_HELPER_REG_EN
            pend_d = 1'b1;
`endif
            if (last_wr) begin
               out_state_d = res_next;
               cnt_d       = '0;
               state_d     = DONE;
`ifdef INV_COL_HELPER_REG_EN
               pend_d      = 1'b0;
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; every register here is reset, none is a memory.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         st_reg_q    <= '0;
         res_q       <= '0;
         out_state_q <= '0;
`ifdef INV_COL_HELPER_REG_EN
         col_in_q    <= '0;
         pend_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         st_reg_q    <= st_reg_d;
         res_q       <= res_d;
         out_state_q <= out_state_d;
`ifdef INV_COL_HELPER_REG_EN
         col_in_q    <= col_in_d;
         pend_q      <= pend_d;
`endif
      end
   end

endmodule

// File: tb/tb_inv_round_col_sequencer.sv
// Self-checking bench for inv_round_col_sequencer with a behavioural InvMixColumns helper and round model.
module tb_inv_round_col_sequencer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_state = '0;
   logic [127:0] in_key = '0;
   logic         in_skip_mix = 1'b0;
   logic [31:0]  col_out;
   logic [31:0]  col_in;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_state;
   logic         busy;

   int checks = 0;
   int failures = 0;

`ifdef INV_COL_HELPER_REG_EN
   localparam int MIX_LAT = 6;
`else
   localparam int MIX_LAT = 5;
`endif
   localparam int SKIP_LAT = 1;

   always #5 clk = ~clk;

   inv_round_col_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_key(in_key), .in_skip_mix(in_skip_mix),
      .col_out(col_out), .col_in(col_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_state(out_state), .busy(busy)
   );

   // GF(2^8) multiply by shift-and-add with the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] r [4];
      logic [7:0] coef [4];
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      for (int row = 0; row < 4; row++) begin
         r[row] = 8'h00;
         for (int j = 0; j < 4; j++) r[row] = r[row] ^ gmul(a[j], coef[(j - row + 4) % 4]);
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic sk);
      logic [127:0] t = s ^ k;
      logic [127:0] r = '0;
      if (sk) return t;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix(t[127-32*c -: 32]);
      return r;
   endfunction

   always_comb col_in = inv_mix(col_out);

   task automatic send_block(input logic [127:0] s, input logic [127:0] k, input logic sk, output bit ok);
      in_state = s; in_key = k; in_skip_mix = sk; in_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat, output logic [127:0] res);
      lat = 0; res = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin lat = i; res = out_state; break; end
      end
   endtask

   task automatic release_out(input int stall);
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk); checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== '0 || col_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b busy=%b state=%h col=%h want 0/0/0/0", out_valid, busy, out_state, col_out);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk); checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL reset_release got ready=%b busy=%b want 1/0", in_ready, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mix_vectors;
      logic [127:0] vs [4];
      logic [127:0] vk [4];
      logic [127:0] ve [4];
      logic         vsk [4];
      int           vl [4];
      bit ok; int lat; logic [127:0] res;
      vs[0] = {4{32'h8e4da1bc}}; vk[0] = '0;                 vsk[0] = 1'b0; ve[0] = {4{32'hdb135345}}; vl[0] = MIX_LAT;
      vs[1] = '0;                vk[1] = {4{32'h8e4da1bc}}; vsk[1] = 1'b0; ve[1] = {4{32'hdb135345}}; vl[1] = MIX_LAT;
      vs[2] = {4{32'h01010101}}; vk[2] = '0;                 vsk[2] = 1'b0; ve[2] = {4{32'h01010101}}; vl[2] = MIX_LAT;
      vs[3] = 128'h00112233445566778899aabbccddeeff; vk[3] = 128'h000102030405060708090a0b0c0d0e0f;
      vsk[3] = 1'b1; ve[3] = 128'h00102030405060708090a0b0c0d0e0f0; vl[3] = SKIP_LAT;
      for (int v = 0; v < 4; v++) begin
         send_block(vs[v], vk[v], vsk[v], ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL vec%0d_accept got=timeout want=accepted", v); continue; end
         wait_out(lat, res);
         checks++;
         if (lat != vl[v]) begin failures++; $display("FAIL vec%0d_latency got=%0d want=%0d", v, lat, vl[v]); end
         checks++;
         if (res !== ve[v]) begin failures++; $display("FAIL vec%0d_state got=%h want=%h", v, res, ve[v]); end
         release_out(0);
      end
   endtask

   task automatic test_backpressure;
      bit ok; int lat; logic [127:0] res, s, k, exp;
      s = {$urandom, $urandom, $urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_round(s, k, 1'b0);
      send_block(s, k, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_accept got=timeout want=accepted"); return; end
      wait_out(lat, res);
      checks++;
      if (res !== exp) begin failures++; $display("FAIL bp_state got=%h want=%h", res, exp); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         in_valid = (c == 1); in_state = ~s; in_key = k; in_skip_mix = 1'b1;
         @(negedge clk); checks++;
         if (out_valid !== 1'b1 || out_state !== exp || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d got valid=%b ready=%b state=%h want 1/0/%h", c, out_valid, in_ready, out_state, exp);
         end
      end
      @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk); checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL bp_release got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
      @(posedge clk); #1;
      @(negedge clk); checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept got busy=%b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_mix;
      bit ok; int lat; logic [127:0] res, s, k, exp;
      send_block({4{32'hdeadbeef}}, {4{32'h12345678}}, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midrst_accept got=timeout want=accepted"); return; end
      @(posedge clk); #1;
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL midrst_abort got valid=%b busy=%b ready=%b want 0/0/0", out_valid, busy, in_ready);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk); checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      s = {$urandom, $urandom, $urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_round(s, k, 1'b0);
      send_block(s, k, 1'b0, ok);
      wait_out(lat, res);
      checks++;
      if (!ok || res !== exp || lat != MIX_LAT) begin
         failures++; $display("FAIL midrst_next got=%h lat=%0d want=%h lat=%0d", res, lat, exp, MIX_LAT);
      end
      release_out(0);
   endtask

   task automatic test_random;
      bit ok; int lat; logic [127:0] res, s, k, exp; logic sk;
      for (int n = 0; n < 40; n++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         sk = ($urandom_range(3) == 0);
         exp = ref_round(s, k, sk);
         send_block(s, k, sk, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL rand%0d_accept got=timeout want=accepted", n); continue; end
         wait_out(lat, res);
         checks++;
         if (res !== exp || lat != (sk ? SKIP_LAT : MIX_LAT)) begin
            failures++;
            $display("FAIL rand%0d got=%h lat=%0d want=%h lat=%0d", n, res, lat, exp, sk ? SKIP_LAT : MIX_LAT);
         end
         release_out($urandom_range(3));
      end
   endtask

   initial begin
      test_reset;
      test_mix_vectors;
      test_backpressure;
      test_reset_mid_mix;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finished");
      $fatal(1, "watchdog");
   end

endmodule
